// File: rtl/decode_pkg.sv
// decode_pkg: shared constants for the decode stage.
//   - instruction field bit positions
//   - immediate-format encodings carried on iSignExtCtrl
//   - default parameter values for decode_stage_hs and regfile_2r1w
package decode_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_IC_W   = 8;

  localparam int IR_W      = 32;
  localparam int FIELD_W   = 5;
  localparam int RD_MSB    = 25;
  localparam int RD_LSB    = 21;
  localparam int RS1_MSB   = 20;
  localparam int RS1_LSB   = 16;
  localparam int RS2_MSB   = 15;
  localparam int RS2_LSB   = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int IMM11_MSB = 10;

  typedef enum logic [1:0] {
    ZEXT16 = 2'b00,  // zero-extend imm16
    SEXT16 = 2'b01,  // sign-extend imm16
    LUI16  = 2'b10,  // imm16 placed in the upper half
    SEXT11 = 2'b11   // sign-extend iIR[10:0]
  } sext_e;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x DATA_W register file.
//   Clk, reset        : clock, asynchronous active-low reset (clears all registers)
//   we, wAddr, wData  : synchronous write port; writes to register 0 are dropped
//   rAddr1/rData1     : asynchronous read port 1
//   rAddr2/rData2     : asynchronous read port 2
// Register 0 always reads as zero. A read of the address being written in the
// same cycle returns the incoming write data (write-through).
module regfile_2r1w #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [AW-1:0]     rAddr1,
  output logic [DATA_W-1:0] rData1,
  input  logic [AW-1:0]     rAddr2,
  output logic [DATA_W-1:0] rData2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wAddr != '0)) begin
      regs[wAddr] <= wData;
    end
  end

  always_comb begin
    rData1 = '0;
    if (rAddr1 != '0) begin
      if (we && (wAddr == rAddr1)) rData1 = wData;
      else                         rData1 = regs[rAddr1];
    end
  end

  always_comb begin
    rData2 = '0;
    if (rAddr2 != '0) begin
      if (we && (wAddr == rAddr2)) rData2 = wData;
      else                         rData2 = regs[rAddr2];
    end
  end

endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: instruction decode stage with register read, busy-bit
// scoreboard and a one-entry registered output.
//   Clk, reset           : clock, asynchronous active-low reset
//   iValid/oReady        : instruction offer from fetch / acceptance
//   iIR, iPC, iIC        : instruction word, PC, forwarded control bus
//   iR2Select            : 1 = rs2 taken from the rd field
//   iSignExtCtrl         : immediate format (sext_e)
//   iWritesRd            : instruction will write rd
//   flush                : kill the output entry and refuse the input offer
//   rf_we, WAddr, WData  : writeback port (also clears busy bits)
//   oValid/iReady        : output entry valid / execute accepts it
//   oPC..oIM             : registered decode results
//   oBusy                : scoreboard busy bits, for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. iValid/iIR/... offer an instruction; it is taken when oReady = 1.
// oReady never depends on iValid. The output entry is consumed by execute
// when oValid and iReady are both 1, and holds unchanged while oValid = 1 and
// iReady = 0.
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int PC_W   = DEF_PC_W,
  parameter  int IC_W   = DEF_IC_W,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [IR_W-1:0]   iIR,
  input  logic [PC_W-1:0]   iPC,
  input  logic [IC_W-1:0]   iIC,
  input  logic              iR2Select,
  input  logic [1:0]        iSignExtCtrl,
  input  logic              iWritesRd,
  input  logic              flush,
  input  logic              rf_we,
  input  logic [AW-1:0]     WAddr,
  input  logic [DATA_W-1:0] WData,
  output logic              oValid,
  input  logic              iReady,
  output logic [PC_W-1:0]   oPC,
  output logic [IC_W-1:0]   oIC,
  output logic [AW-1:0]     oRDS,
  output logic [AW-1:0]     oRS1,
  output logic [AW-1:0]     oRS2,
  output logic [DATA_W-1:0] oOP1,
  output logic [DATA_W-1:0] oOP2,
  output logic [DATA_W-1:0] oIM,
  output logic [NREGS-1:0]  oBusy
);

  // Field extraction
  logic [FIELD_W-1:0] rdField, rs1Field, rs2Field;
  logic [15:0]        imm16;
  logic [10:0]        imm11;
  logic [AW-1:0]      rdA, rs1A, rs2A;
  logic               unusedIrBits;

  assign rdField      = iIR[RD_MSB:RD_LSB];
  assign rs1Field     = iIR[RS1_MSB:RS1_LSB];
  assign rs2Field     = iIR[RS2_MSB:RS2_LSB];
  assign imm16        = iIR[IMM_MSB:IMM_LSB];
  assign imm11        = iIR[IMM11_MSB:IMM_LSB];
  assign unusedIrBits = ^iIR[IR_W-1:RD_MSB+1];

  assign rdA  = AW'(rdField);
  assign rs1A = AW'(rs1Field);
  assign rs2A = iR2Select ? rdA : AW'(rs2Field);

  logic [DATA_W-1:0] immVal;
  always_comb begin
    immVal = '0;
    case (sext_e'(iSignExtCtrl))
      ZEXT16:  immVal = DATA_W'(imm16);
      SEXT16:  immVal = DATA_W'($signed(imm16));
      LUI16:   immVal = DATA_W'({imm16, 16'h0000});
      SEXT11:  immVal = DATA_W'($signed(imm11));
      default: immVal = '0;
    endcase
  end

  // Register file
  logic [DATA_W-1:0] rdData1, rdData2;

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS)) uRegfile (
    .Clk    (Clk),
    .reset  (reset),
    .we     (rf_we),
    .wAddr  (WAddr),
    .wData  (WData),
    .rAddr1 (rs1A),
    .rData1 (rdData1),
    .rAddr2 (rs2A),
    .rData2 (rdData2)
  );

  // Scoreboard and hazard detection. A register being written back this
  // cycle is no longer a hazard: the read port forwards WData to it.
  logic [NREGS-1:0] busy, busyNext;
  logic             busyRs1, busyRs2, busyRd, hazard;
  logic             slotFree, load;
  logic             oWritesRd;

  assign busyRs1 = busy[rs1A] && !(rf_we && (WAddr == rs1A));
  assign busyRs2 = busy[rs2A] && !(rf_we && (WAddr == rs2A));
  assign busyRd  = busy[rdA]  && !(rf_we && (WAddr == rdA));
  assign hazard  = busyRs1 || busyRs2 || (iWritesRd && busyRd);

  assign slotFree = !oValid || iReady;
  // The reset term keeps oReady low while reset is asserted even though the
  // cleared state alone would make the slot look free.
  assign oReady   = reset && slotFree && !hazard && !flush;
  assign load     = iValid && oReady;
  assign oBusy    = busy;

  // Clears are applied before the set so that an instruction re-claiming a
  // register being written back this cycle leaves it busy.
  always_comb begin
    busyNext = busy;
    if (rf_we) busyNext[WAddr] = 1'b0;
    if (flush && oValid && oWritesRd) busyNext[oRDS] = 1'b0;
    if (load && iWritesRd && (rdA != '0)) busyNext[rdA] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Output register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      oValid    <= 1'b0;
      oWritesRd <= 1'b0;
      oPC       <= '0;
      oIC       <= '0;
      oRDS      <= '0;
      oRS1      <= '0;
      oRS2      <= '0;
      oOP1      <= '0;
      oOP2      <= '0;
      oIM       <= '0;
    end else begin
      busy <= busyNext;
      if (flush) begin
        oValid <= 1'b0;
      end else if (load) begin
        oValid    <= 1'b1;
        oWritesRd <= iWritesRd && (rdA != '0);
        oPC       <= iPC;
        oIC       <= iIC;
        oRDS      <= rdA;
        oRS1      <= rs1A;
        oRS2      <= rs2A;
        oOP1      <= rdData1;
        oOP2      <= rdData2;
        oIM       <= immVal;
      end else if (slotFree) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
module tb_decode_stage_hs;
  import decode_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int PC_W   = 32;
  localparam int IC_W   = 8;
  localparam int AW     = 5;
  localparam int EW     = PC_W + IC_W + 3*AW + 3*DATA_W;

  logic              Clk, reset;
  logic              iValid, oReady;
  logic [31:0]       iIR;
  logic [PC_W-1:0]   iPC;
  logic [IC_W-1:0]   iIC;
  logic              iR2Select, iWritesRd, flush, rf_we, oValid, iReady;
  logic [1:0]        iSignExtCtrl;
  logic [AW-1:0]     WAddr;
  logic [DATA_W-1:0] WData;
  logic [PC_W-1:0]   oPC;
  logic [IC_W-1:0]   oIC;
  logic [AW-1:0]     oRDS, oRS1, oRS2;
  logic [DATA_W-1:0] oOP1, oOP2, oIM;
  logic [NREGS-1:0]  oBusy;

  int checks = 0;
  int errors = 0;

  // Scoreboard: entries expected on the output, plus the register each
  // entry will write (0 = none).
  logic [EW-1:0]     exp_q[$];
  int                wrd_q[$];
  logic [31:0]       mReg[NREGS];
  logic [NREGS-1:0]  mBusy;

  // Clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  decode_stage_hs dut (
    .Clk(Clk), .reset(reset), .iValid(iValid), .oReady(oReady), .iIR(iIR),
    .iPC(iPC), .iIC(iIC), .iR2Select(iR2Select), .iSignExtCtrl(iSignExtCtrl),
    .iWritesRd(iWritesRd), .flush(flush), .rf_we(rf_we), .WAddr(WAddr),
    .WData(WData), .oValid(oValid), .iReady(iReady), .oPC(oPC), .oIC(oIC),
    .oRDS(oRDS), .oRS1(oRS1), .oRS2(oRS2), .oOP1(oOP1), .oOP2(oOP2),
    .oIM(oIM), .oBusy(oBusy)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model helpers
  function automatic logic [EW-1:0] pack(input logic [31:0] pc, input logic [7:0] ic,
                                         input logic [4:0] rds, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] op1,
                                         input logic [31:0] op2, input logic [31:0] im);
    return {pc, ic, rds, rs1, rs2, op1, op2, im};
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'h0;
    if (rf_we && (int'(WAddr) == a)) return WData;
    return mReg[a];
  endfunction

  function automatic bit m_busy(input int a);
    return mBusy[a] && !(rf_we && (int'(WAddr) == a));
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ir, input logic [1:0] mode);
    int unsigned v16, v11;
    v16 = ir & 32'hFFFF;
    v11 = ir & 32'h7FF;
    case (mode)
      2'd0: return v16;
      2'd1: return (v16 >= 32768) ? v16 + 32'hFFFF0000 : v16;
      2'd2: return v16 * 65536;
      default: return (v11 >= 1024) ? v11 + 32'hFFFFF800 : v11;
    endcase
  endfunction

  function automatic logic [31:0] mk_ir(input int rd, input int rs1, input logic [15:0] imm);
    return {6'b0, 5'(rd), 5'(rs1), imm};
  endfunction

  // Driver tasks
  task automatic offer(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                       input logic wr, input logic [1:0] mode, input logic sel);
    iValid = v; iIR = ir; iPC = pc; iIC = pc[7:0] ^ 8'h5A;
    iWritesRd = wr; iSignExtCtrl = mode; iR2Select = sel;
  endtask

  task automatic wb(input logic we, input int a, input logic [31:0] d);
    rf_we = we; WAddr = 5'(a); WData = d;
  endtask

  task automatic model_reset();
    mBusy = '0;
    for (int i = 0; i < NREGS; i++) mReg[i] = 32'h0;
    exp_q.delete();
    wrd_q.delete();
  endtask

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic step(input string tag);
    int rd, rs1, rs2;
    bit haz, expRdy, ld;
    logic [EW-1:0] ent;
    #1;
    rd  = int'(iIR[25:21]);
    rs1 = int'(iIR[20:16]);
    rs2 = iR2Select ? rd : int'(iIR[15:11]);
    haz = m_busy(rs1) || m_busy(rs2) || (iWritesRd && m_busy(rd));
    expRdy = ((exp_q.size() == 0) || iReady) && !haz && !flush;
    check({tag, " oReady"}, 160'(oReady), 160'(expRdy));
    ld  = iValid && expRdy;
    ent = pack(iPC, iIC, 5'(rd), 5'(rs1), 5'(rs2), m_read(rs1), m_read(rs2),
               m_imm(iIR, iSignExtCtrl));
    @(posedge Clk);
    if ((exp_q.size() != 0) && (iReady || flush)) begin
      if (flush && (wrd_q[0] != 0)) mBusy[wrd_q[0]] = 1'b0;
      void'(exp_q.pop_front());
      void'(wrd_q.pop_front());
    end
    if (rf_we) begin
      mBusy[WAddr] = 1'b0;
      if (WAddr != 0) mReg[WAddr] = WData;
    end
    if (ld) begin
      exp_q.push_back(ent);
      wrd_q.push_back(iWritesRd ? rd : 0);
      if (iWritesRd && (rd != 0)) mBusy[rd] = 1'b1;
    end
    #1;
    check({tag, " oValid"}, 160'(oValid), 160'(exp_q.size() != 0));
    check({tag, " busy"}, 160'(oBusy), 160'(mBusy));
    if (exp_q.size() != 0)
      check({tag, " entry"}, 160'(pack(oPC, oIC, oRDS, oRS1, oRS2, oOP1, oOP2, oIM)),
            160'(exp_q[0]));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " oValid"}, 160'(oValid), 160'(0));
    check({tag, " oReady"}, 160'(oReady), 160'(0));
    check({tag, " busy"},   160'(oBusy),  160'(0));
    check({tag, " data"},   160'(pack(oPC, oIC, oRDS, oRS1, oRS2, oOP1, oOP2, oIM)), 160'(0));
  endtask

  logic [31:0] immExp[4];
  logic [EW-1:0] held;

  initial begin
    // Reset
    reset = 1'b1;
    offer(1'b1, mk_ir(1, 2, 16'h1234), 32'h40, 1'b1, 2'd0, 1'b0);
    wb(1'b0, 0, 32'h0);
    flush = 1'b0; iReady = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #2 check_cleared("reset");
    #9 reset = 1'b1;  // t=12, first rising edge follows at t=15

    // Four back-to-back independent instructions
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, mk_ir(k + 1, k + 8, 16'(k * 3)), 32'h100 + 32'(4 * k), 1'b0, 2'd1, 1'b0);
      step("stream");
      check("stream oPC", 160'(oPC), 160'(32'h100 + 32'(4 * k)));
      check("stream valid", 160'(oValid), 160'(1));
    end
    offer(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    step("stream drain");

    // RAW on r5, released by writeback with bypass
    offer(1'b1, mk_ir(5, 0, 16'h0000), 32'h200, 1'b1, 2'd0, 1'b0);
    step("raw producer");
    offer(1'b1, mk_ir(6, 5, 16'h0000), 32'h204, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("raw stall");
      check("raw stall oReady", 160'(oReady), 160'(0));
    end
    wb(1'b1, 5, 32'hDEADBEEF);
    step("raw release");
    check("raw oOP1", 160'(oOP1), 160'(32'hDEADBEEF));
    wb(1'b0, 0, 32'h0);

    // Backpressure
    offer(1'b1, mk_ir(9, 5, 16'h0042), 32'h300, 1'b0, 2'd0, 1'b0);
    step("bp load");
    held = pack(oPC, oIC, oRDS, oRS1, oRS2, oOP1, oOP2, oIM);
    iReady = 1'b0;
    offer(1'b1, mk_ir(10, 0, 16'h0077), 32'h304, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("bp hold");
      check("bp stable", 160'(pack(oPC, oIC, oRDS, oRS1, oRS2, oOP1, oOP2, oIM)), 160'(held));
    end
    iReady = 1'b1;
    step("bp resume");
    check("bp next oPC", 160'(oPC), 160'(32'h304));

    // Flush of an entry that writes r7
    offer(1'b1, mk_ir(7, 0, 16'h0000), 32'h400, 1'b1, 2'd0, 1'b0);
    step("flush load");
    iReady = 1'b0; flush = 1'b1;
    offer(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    step("flush");
    check("flush oValid", 160'(oValid), 160'(0));
    check("flush busy7", 160'(oBusy[7]), 160'(0));
    flush = 1'b0; iReady = 1'b1;
    offer(1'b1, mk_ir(0, 7, 16'h0000), 32'h404, 1'b0, 2'd0, 1'b0);
    #1 check("flush reader ready", 160'(oReady), 160'(1));
    step("flush reader");

    // Immediate formats
    immExp[0] = 32'h00008001; immExp[1] = 32'hFFFF8001;
    immExp[2] = 32'h80010000; immExp[3] = 32'h00000001;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, mk_ir(0, 0, 16'h8001), 32'h500 + 32'(4 * k), 1'b0, 2'(k), 1'b0);
      step("imm");
      check("imm oIM", 160'(oIM), 160'(immExp[k]));
    end

    // Randomized traffic with frequent hazards on r0..r7
    for (int n = 0; n < 300; n++) begin
      offer(($urandom_range(0, 3) != 0),
            mk_ir($urandom_range(0, 7), $urandom_range(0, 7),
                  {5'($urandom_range(0, 7)), 11'($urandom)}),
            $urandom, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
      iReady = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 15) == 0);
      wb(($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom);
      step("rand");
    end

    // Clean reset, then asynchronous reset in the middle of a stall
    flush = 1'b0; wb(1'b0, 0, 32'h0);
    reset = 1'b0;
    model_reset();
    #1 check_cleared("reset2");
    @(posedge Clk); #1;
    reset = 1'b1;
    iReady = 1'b0;
    offer(1'b1, mk_ir(3, 0, 16'h0011), 32'h600, 1'b1, 2'd0, 1'b0);
    step("stall load");
    offer(1'b1, mk_ir(4, 3, 16'h0000), 32'h604, 1'b0, 2'd0, 1'b0);
    step("stall");
    check("stall valid", 160'(oValid), 160'(1));
    check("stall busy3", 160'(oBusy[3]), 160'(1));
    #2 reset = 1'b0;
    #1 check_cleared("async reset");
    model_reset();
    @(posedge Clk); #1;
    reset = 1'b1;
    iReady = 1'b1;
    step("post reset");
    step("post reset 2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
